// File: rtl/branch_pkg.sv
// -----------------------------------------------------------------------------
// branch_pkg
// Shared definitions for the ID-stage branch resolution unit.
//   - BR_* : branch condition codes carried on req_op
//   - CTR_*: 2-bit saturating predictor counter states
//   - br_eval(): condition evaluation from pre-computed operand flags, so the
//     function stays independent of the operand width
// -----------------------------------------------------------------------------
package branch_pkg;

    localparam logic [2:0] BR_NONE = 3'b000;  // never taken, never accepted
    localparam logic [2:0] BR_EQ   = 3'b001;  // a == b
    localparam logic [2:0] BR_NE   = 3'b010;  // a != b
    localparam logic [2:0] BR_GEZ  = 3'b011;  // a >= 0 (signed)
    localparam logic [2:0] BR_GTZ  = 3'b100;  // a >  0 (signed)
    localparam logic [2:0] BR_LEZ  = 3'b101;  // a <= 0 (signed)
    localparam logic [2:0] BR_LTZ  = 3'b110;  // a <  0 (signed)
    localparam logic [2:0] BR_JMP  = 3'b111;  // unconditional

    localparam logic [1:0] CTR_SNT = 2'b00;   // strongly not-taken
    localparam logic [1:0] CTR_WNT = 2'b01;   // weakly not-taken
    localparam logic [1:0] CTR_WT  = 2'b10;   // weakly taken
    localparam logic [1:0] CTR_ST  = 2'b11;   // strongly taken

    // a_neg is the operand sign bit and a_zero flags an all-zero operand;
    // together they give every signed compare against zero.
    function automatic logic br_eval(input logic [2:0] op,
                                     input logic       a_eq_b,
                                     input logic       a_neg,
                                     input logic       a_zero);
        logic r;
        r = 1'b0;
        case (op)
            BR_EQ:   r = a_eq_b;
            BR_NE:   r = !a_eq_b;
            BR_GEZ:  r = !a_neg;
            BR_GTZ:  r = !a_neg && !a_zero;
            BR_LEZ:  r = a_neg || a_zero;
            BR_LTZ:  r = a_neg;
            BR_JMP:  r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/branch_bht.sv
// -----------------------------------------------------------------------------
// branch_bht
// DEPTH-entry table of 2-bit saturating counters.
// Ports:
//   clk, rst_n        clock / asynchronous active-low reset (entries -> WNT)
//   rd_idx, rd_ctr    combinational read port
//   we, wr_idx,       update port: on we, counter at wr_idx moves one step
//   wr_taken          toward taken (1) or not-taken (0), saturating
// A read of the entry being written returns the old value this cycle.
// -----------------------------------------------------------------------------
module branch_bht
    import branch_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int IDXW  = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [IDXW-1:0] rd_idx,
    output logic [1:0]      rd_ctr,
    input  logic            we,
    input  logic [IDXW-1:0] wr_idx,
    input  logic            wr_taken
);

    logic [1:0] ctr_q [DEPTH];
    logic [1:0] cur;

    assign cur    = ctr_q[wr_idx];
    assign rd_ctr = ctr_q[rd_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                ctr_q[i] <= CTR_WNT;
            end
        end else if (we) begin
            if (wr_taken && cur != CTR_ST) begin
                ctr_q[wr_idx] <= cur + 2'd1;
            end else if (!wr_taken && cur != CTR_SNT) begin
                ctr_q[wr_idx] <= cur - 2'd1;
            end
        end
    end

endmodule

// File: rtl/branch_unit.sv
// -----------------------------------------------------------------------------
// branch_unit
// ID-stage branch resolution: signed condition evaluation, registered outcome,
// 2-bit counter prediction table and saturating statistics.
// Ports:
//   clk, rst_n                 clock / asynchronous active-low reset
//   lk_idx, lk_taken           IF lookup (combinational prediction)
//   en                         pipeline enable, 0 stalls all result/table state
//   req_valid, req_op, req_a,  resolve request from ID
//   req_b, req_idx, req_pred
//   res_valid, res_taken,      registered outcome, one cycle after accept
//   res_mispredict
//   stat_clr, stat_br,         statistics clear and saturating counts
//   stat_mis
// Handshake: there is no ready; a request is taken on any edge where
// req_valid && en && req_op != BR_NONE. res_valid is a one-cycle pulse per
// accept that holds (with res_taken/res_mispredict) while en is low.
// -----------------------------------------------------------------------------
module branch_unit
    import branch_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 16,
    parameter  int CNTW  = 16,
    localparam int IDXW  = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDXW-1:0]  lk_idx,
    output logic             lk_taken,
    input  logic             en,
    input  logic             req_valid,
    input  logic [2:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [IDXW-1:0]  req_idx,
    input  logic             req_pred,
    output logic             res_valid,
    output logic             res_taken,
    output logic             res_mispredict,
    input  logic             stat_clr,
    output logic [CNTW-1:0]  stat_br,
    output logic [CNTW-1:0]  stat_mis
);

    localparam logic [CNTW-1:0] STAT_MAX = {CNTW{1'b1}};

    logic       accept;
    logic       cond;
    logic       mis;
    logic       tbl_we;
    logic [1:0] lk_ctr;

    assign accept = req_valid && en && (req_op != BR_NONE);
    assign cond   = br_eval(req_op, req_a == req_b, req_a[WIDTH-1], req_a == '0);
    assign mis    = cond != req_pred;
    // Unconditional jumps carry no direction information for the predictor.
    assign tbl_we = accept && (req_op != BR_JMP);

    branch_bht #(
        .DEPTH(DEPTH)
    ) u_bht (
        .clk     (clk),
        .rst_n   (rst_n),
        .rd_idx  (lk_idx),
        .rd_ctr  (lk_ctr),
        .we      (tbl_we),
        .wr_idx  (req_idx),
        .wr_taken(cond)
    );

    assign lk_taken = lk_ctr[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid      <= 1'b0;
            res_taken      <= 1'b0;
            res_mispredict <= 1'b0;
        end else if (en) begin
            res_valid      <= accept;
            res_taken      <= accept && cond;
            res_mispredict <= accept && mis;
        end
    end

    // Clear takes priority over a same-cycle accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_br  <= '0;
            stat_mis <= '0;
        end else if (stat_clr) begin
            stat_br  <= '0;
            stat_mis <= '0;
        end else if (accept) begin
            if (stat_br != STAT_MAX) begin
                stat_br <= stat_br + 1'b1;
            end
            if (mis && stat_mis != STAT_MAX) begin
                stat_mis <= stat_mis + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_branch_unit.sv
// -----------------------------------------------------------------------------
// tb_branch_unit
// Directed bench for branch_unit (WIDTH=32, DEPTH=16, CNTW=4). Expected
// outcomes are pushed to exp_q as each request is driven and popped after the
// capturing edge; predictor table and statistics are modelled alongside.
// -----------------------------------------------------------------------------
module tb_branch_unit;

    logic        clk;
    logic        rst_n;
    logic [3:0]  lk_idx;
    logic        lk_taken;
    logic        en;
    logic        req_valid;
    logic [2:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [3:0]  req_idx;
    logic        req_pred;
    logic        res_valid;
    logic        res_taken;
    logic        res_mispredict;
    logic        stat_clr;
    logic [3:0]  stat_br;
    logic [3:0]  stat_mis;

    branch_unit #(
        .WIDTH(32),
        .DEPTH(16),
        .CNTW (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .lk_idx        (lk_idx),
        .lk_taken      (lk_taken),
        .en            (en),
        .req_valid     (req_valid),
        .req_op        (req_op),
        .req_a         (req_a),
        .req_b         (req_b),
        .req_idx       (req_idx),
        .req_pred      (req_pred),
        .res_valid     (res_valid),
        .res_taken     (res_taken),
        .res_mispredict(res_mispredict),
        .stat_clr      (stat_clr),
        .stat_br       (stat_br),
        .stat_mis      (stat_mis)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard / model state ----------------
    logic [2:0] exp_q [$];       // {valid, taken, mispredict}
    logic [1:0] tbl [16];
    logic [2:0] m_res;
    int         m_br;
    int         m_mis;
    int         n_cmp;
    int         n_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic model_cond(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'd1:    return a == b;
            3'd2:    return a != b;
            3'd3:    return $signed(a) >= 0;
            3'd4:    return $signed(a) > 0;
            3'd5:    return $signed(a) <= 0;
            3'd6:    return $signed(a) < 0;
            3'd7:    return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) tbl[i] = 2'b01;
        m_res = 3'b000;
        m_br  = 0;
        m_mis = 0;
        exp_q.delete();
    endtask

    // One clock of stimulus; called at posedge+1, returns at next posedge+1.
    task automatic step(input logic t_en, input logic t_valid, input logic [2:0] t_op,
                        input logic [31:0] t_a, input logic [31:0] t_b,
                        input logic [3:0] t_idx, input logic t_pred, input logic t_clr);
        logic       acc;
        logic       c;
        logic [2:0] e;
        logic [2:0] got;
        int         nb;
        int         nm;
        en = t_en; req_valid = t_valid; req_op = t_op; req_a = t_a; req_b = t_b;
        req_idx = t_idx; req_pred = t_pred; stat_clr = t_clr;
        acc = t_en && t_valid && (t_op != 3'd0);
        c   = model_cond(t_op, t_a, t_b);
        if (t_en) e = acc ? {1'b1, c, c != t_pred} : 3'b000;
        else      e = m_res;
        m_res = e;
        exp_q.push_back(e);
        nb = m_br; nm = m_mis;
        if (t_clr) begin
            nb = 0; nm = 0;
        end else if (acc) begin
            if (nb < 15) nb++;
            if (c != t_pred && nm < 15) nm++;
        end
        #1;
        check("lk_pre", 32'(lk_taken), 32'(tbl[lk_idx][1]));
        @(posedge clk); #1;
        if (acc && t_op != 3'd7) begin
            if (c && tbl[t_idx] != 2'b11)       tbl[t_idx] = tbl[t_idx] + 2'd1;
            else if (!c && tbl[t_idx] != 2'b00) tbl[t_idx] = tbl[t_idx] - 2'd1;
        end
        m_br = nb; m_mis = nm;
        got = exp_q.pop_front();
        check("res", 32'({res_valid, res_taken, res_mispredict}), 32'(got));
        check("stat_br", 32'(stat_br), 32'(m_br));
        check("stat_mis", 32'(stat_mis), 32'(m_mis));
        check("lk_post", 32'(lk_taken), 32'(tbl[lk_idx][1]));
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 3'd0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        n_cmp = 0; n_err = 0;
        rst_n = 1'b0; lk_idx = 4'd0; en = 1'b0; req_valid = 1'b0; req_op = 3'd0;
        req_a = '0; req_b = '0; req_idx = '0; req_pred = 1'b0; stat_clr = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Reset state
        for (int i = 0; i < 16; i++) begin
            lk_idx = 4'(i);
            #1;
            check("reset_lk", 32'(lk_taken), 32'd0);
        end
        check("reset_res_valid", 32'(res_valid), 32'd0);
        check("reset_stat_br", 32'(stat_br), 32'd0);
        check("reset_stat_mis", 32'(stat_mis), 32'd0);

        // Signed compares against zero
        lk_idx = 4'd1;
        step(1'b1, 1'b1, 3'd6, 32'h8000_0000, 32'd0, 4'd1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 3'd4, 32'hFFFF_FFFF, 32'd0, 4'd2, 1'b0, 1'b0);
        step(1'b1, 1'b1, 3'd3, 32'h0000_0000, 32'd7, 4'd4, 1'b0, 1'b0);
        step(1'b1, 1'b1, 3'd5, 32'h0000_0000, 32'd0, 4'd7, 1'b1, 1'b0);
        step(1'b1, 1'b1, 3'd4, 32'h0000_0001, 32'd0, 4'd7, 1'b1, 1'b0);
        // op 000 with valid is not accepted; op 111 accepted, no table change
        step(1'b1, 1'b1, 3'd0, 32'd5, 32'd5, 4'd7, 1'b1, 1'b0);
        lk_idx = 4'd9;
        step(1'b1, 1'b1, 3'd7, 32'd0, 32'd1, 4'd9, 1'b0, 1'b0);

        // Random mix on the upper half of the table
        for (int i = 0; i < 12; i++) begin
            ra = $urandom;
            rb = ($urandom_range(1, 0) == 1) ? ra : $urandom;
            lk_idx = 4'($urandom_range(15, 8));
            step(1'b1, 1'($urandom_range(1, 0)), 3'($urandom_range(7, 0)), ra, rb,
                 4'($urandom_range(15, 8)), 1'($urandom_range(1, 0)), 1'b0);
        end

        // Training at idx 3 with pred=0
        step(1'b1, 1'b0, 3'd0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b1);
        lk_idx = 4'd3;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, 3'd1, 32'h1234_5678, 32'h1234_5678, 4'd3, 1'b0, 1'b0);
        end
        check("train_stat_br", 32'(stat_br), 32'd4);
        check("train_stat_mis", 32'(stat_mis), 32'd4);
        check("train_lk3", 32'(lk_taken), 32'd1);

        // Stall: result, stats and table hold while en=0
        step(1'b1, 1'b0, 3'd0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b1);
        lk_idx = 4'd6;
        step(1'b1, 1'b1, 3'd2, 32'd1, 32'd2, 4'd6, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 3'd1, 32'd1, 32'd2, 4'd6, 1'b1, 1'b0);
        end
        check("stall_taken", 32'(res_taken), 32'd1);
        check("stall_stat_br", 32'(stat_br), 32'd1);
        check("stall_lk6", 32'(lk_taken), 32'd1);

        // Lookup/update collision at idx 5 (pre-update value first)
        lk_idx = 4'd5;
        step(1'b1, 1'b1, 3'd1, 32'd9, 32'd9, 4'd5, 1'b1, 1'b0);
        check("collide_lk5", 32'(lk_taken), 32'd1);

        // Statistics saturation, then clear together with an accept
        step(1'b1, 1'b0, 3'd0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b1);
        lk_idx = 4'd12;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b1, 3'($urandom_range(7, 1)), $urandom, $urandom,
                 4'($urandom_range(15, 8)), 1'($urandom_range(1, 0)), 1'b0);
        end
        check("sat_stat_br", 32'(stat_br), 32'd15);
        step(1'b1, 1'b1, 3'd7, 32'd0, 32'd0, 4'd8, 1'b0, 1'b1);
        check("clr_stat_br", 32'(stat_br), 32'd0);
        check("clr_stat_mis", 32'(stat_mis), 32'd0);
        idle();

        // Asynchronous reset with a request in flight
        lk_idx = 4'd3;
        en = 1'b1; req_valid = 1'b1; req_op = 3'd7; req_idx = 4'd3; req_pred = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("areset_res_valid", 32'(res_valid), 32'd0);
        check("areset_lk3", 32'(lk_taken), 32'd0);
        check("areset_stat_br", 32'(stat_br), 32'd0);
        en = 1'b0; req_valid = 1'b0; req_op = 3'd0;
        @(negedge clk) rst_n = 1'b1;
        model_reset();
        @(posedge clk); #1;
        check("post_reset_res_valid", 32'(res_valid), 32'd0);
        idle();
        step(1'b1, 1'b1, 3'd2, 32'd3, 32'd3, 4'd3, 1'b1, 1'b0);
        check("post_reset_lk3", 32'(lk_taken), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
